// File: rtl/fetch_stage.sv
// fetch_stage: PC register, IF/ID register and single-outstanding instruction-memory fetch
// Ports: clk/reset (sync, active-high); PcWrite/if_idWrite/pc_src/address_out from hazard unit;
//        imem_req/imem_addr/imem_ready/imem_rdata memory handshake; pc, instruction_id, pc_id, valid_id to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PcWrite,
    input  logic        if_idWrite,
    input  logic        pc_src,
    input  logic [31:0] address_out,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction_id,
    output logic [31:0] pc_id,
    output logic        valid_id
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
    state_t      state_q;
    logic [31:0] pc_q, addr_q, instr_q, pc_id_q, skid_instr_q, skid_pc_q;
    logic        req_q, kill_q, valid_q;
    logic [31:0] pc_d;
    logic        wait_open;
    assign pc_d      = PcWrite ? pc_q + 32'd4 : pc_q;
    // a redirect that lands while a response is still outstanding must wait for it and discard it
    assign wait_open = state_q == S_WAIT && !imem_ready;
    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign pc             = pc_q;
    assign instruction_id = instr_q;
    assign pc_id          = pc_id_q;
    assign valid_id       = valid_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            kill_q       <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_id_q      <= 32'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 32'h0;
        end else if (pc_src) begin
            pc_q    <= {address_out[31:2], 2'b00};
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            kill_q  <= wait_open;
            req_q   <= wait_open;
            state_q <= wait_open ? S_WAIT : S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                    state_q <= S_WAIT;
                    if (if_idWrite) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_ready) begin
                        req_q <= 1'b0;
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                            if (if_idWrite) begin
                                instr_q <= NOP_INSTR;
                                valid_q <= 1'b0;
                            end
                        end else if (if_idWrite) begin
                            instr_q <= imem_rdata;
                            pc_id_q <= addr_q;
                            valid_q <= 1'b1;
                            pc_q    <= pc_d;
                            state_q <= S_REQ;
                        end else begin
                            skid_instr_q <= imem_rdata;
                            skid_pc_q    <= addr_q;
                            state_q      <= S_HOLD;
                        end
                    end else if (if_idWrite) begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (if_idWrite) begin
                        instr_q <= skid_instr_q;
                        pc_id_q <= skid_pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_d;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end
endmodule
